// File: rtl/divide.sv
// divide: iterative radix-2 restoring integer divider for RV64M
// DIV/DIVU/REM/REMU and their W forms. One quotient bit per cycle;
// divide-by-zero and signed overflow bypass the loop and resolve in FIX.
//
// state | meaning
// IDLE  | waiting for an issue; the only state with div_stall_o low
// CALC  | one restoring step per cycle, down-counter runs to 0
// FIX   | sign correction / special result, strobe writeback
module divide #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic            div_instr_i,
  input  logic [3:0]      div_func_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            word_op_i,
  input  logic            flush_i,
  input  logic            kill_i,
  output logic [XLEN-1:0] div_res_o,
  output logic            valid_res_o,
  output logic [4:0]      rd_addr_o,
  output logic            div_stall_o
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  // func encodings shared with the decoder (funct3 of the M-extension ops)
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_DIVU = 4'b0101;
  localparam logic [3:0] OP_REM  = 4'b0110;
  localparam logic [3:0] OP_REMU = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] b_abs_q;
  logic [3:0]      func_q;
  logic [4:0]      rd_q;
  logic            word_q;
  logic            sign_a_q;
  logic            sign_b_q;
  logic            special_q;

  logic            accept;
  logic            in_known;
  logic            in_signed;
  logic            in_sign_a;
  logic            in_sign_b;
  logic            in_b_zero;
  logic            in_ovf;
  logic            in_special;
  logic [XLEN-1:0] a_sx, a_zx, b_sx, b_zx;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] most_neg;
  logic [XLEN-1:0] spec_quo, spec_rem;
  logic [CW-1:0]   cnt_init;

  logic            quo_msb;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] step_rem, step_quo;

  logic            fix_known;
  logic            fix_is_rem;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic [XLEN-1:0] res_raw, res_w;
  logic [XLEN-1:0] fix_res;

  assign accept = (state_q == S_IDLE) && div_instr_i && !kill_i;

  // Condition the operands offered this cycle: width select, sign, magnitude, special cases
  always_comb begin
    in_known  = (div_func_i == OP_DIV) || (div_func_i == OP_DIVU) ||
                (div_func_i == OP_REM) || (div_func_i == OP_REMU);
    in_signed = (div_func_i == OP_DIV) || (div_func_i == OP_REM);
    if (word_op_i) begin
      a_sx      = {{HALF{opr_a_i[HALF-1]}}, opr_a_i[HALF-1:0]};
      a_zx      = {{HALF{1'b0}}, opr_a_i[HALF-1:0]};
      b_sx      = {{HALF{opr_b_i[HALF-1]}}, opr_b_i[HALF-1:0]};
      b_zx      = {{HALF{1'b0}}, opr_b_i[HALF-1:0]};
      in_b_zero = (opr_b_i[HALF-1:0] == '0);
      most_neg  = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
      cnt_init  = CW'(HALF - 1);
    end else begin
      a_sx      = opr_a_i;
      a_zx      = opr_a_i;
      b_sx      = opr_b_i;
      b_zx      = opr_b_i;
      in_b_zero = (opr_b_i == '0);
      most_neg  = {1'b1, {(XLEN-1){1'b0}}};
      cnt_init  = CW'(XLEN - 1);
    end
    in_sign_a  = in_signed && a_sx[XLEN-1];
    in_sign_b  = in_signed && b_sx[XLEN-1];
    // W magnitudes stay within 32 bits because the sign-extended value is negated
    a_abs      = in_sign_a ? -a_sx : a_zx;
    b_abs      = in_sign_b ? -b_sx : b_zx;
    in_ovf     = in_signed && (a_sx == most_neg) && (b_sx == '1);
    in_special = in_known && (in_b_zero || in_ovf);
    spec_quo   = in_b_zero ? '1 : a_sx;
    spec_rem   = in_b_zero ? a_sx : '0;
  end

  // One restoring step: trial subtract, keep on no-borrow, otherwise restore
  always_comb begin
    quo_msb  = word_q ? quo_q[HALF-1] : quo_q[XLEN-1];
    trial    = {rem_q, quo_msb} - {1'b0, b_abs_q};
    // on borrow {rem,msb} < |b|, so it fits back into XLEN bits
    step_rem = trial[XLEN] ? {rem_q[XLEN-2:0], quo_msb} : trial[XLEN-1:0];
    step_quo = {quo_q[XLEN-2:0], ~trial[XLEN]};
  end

  // Final result: sign fix, W sign-extension, special-case passthrough, unknown func -> 0
  always_comb begin
    fix_known  = (func_q == OP_DIV) || (func_q == OP_DIVU) ||
                 (func_q == OP_REM) || (func_q == OP_REMU);
    fix_is_rem = (func_q == OP_REM) || (func_q == OP_REMU);
    quo_fix    = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
    rem_fix    = sign_a_q ? -rem_q : rem_q;
    res_raw    = fix_is_rem ? rem_fix : quo_fix;
    res_w      = word_q ? {{HALF{res_raw[HALF-1]}}, res_raw[HALF-1:0]} : res_raw;
    if (!fix_known) begin
      fix_res = '0;
    end else if (special_q) begin
      // special results were already formed at accept
      fix_res = fix_is_rem ? rem_q : quo_q;
    end else begin
      fix_res = res_w;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: flush wins over everything outside IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = in_special ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stall is a pure decode of the state register
  always_comb begin
    div_stall_o = (state_q != S_IDLE);
  end

  // Datapath and writeback registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      b_abs_q     <= '0;
      func_q      <= '0;
      rd_q        <= '0;
      word_q      <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      special_q   <= 1'b0;
      div_res_o   <= '0;
      rd_addr_o   <= '0;
      valid_res_o <= 1'b0;
    end else begin
      valid_res_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            func_q    <= div_func_i;
            rd_q      <= rd_addr_i;
            word_q    <= word_op_i;
            sign_a_q  <= in_sign_a;
            sign_b_q  <= in_sign_b;
            special_q <= in_special;
            b_abs_q   <= b_abs;
            cnt_q     <= cnt_init;
            if (in_special) begin
              quo_q <= spec_quo;
              rem_q <= spec_rem;
            end else begin
              quo_q <= a_abs;
              rem_q <= '0;
            end
          end
        end
        S_CALC: begin
          if (!flush_i) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          if (!flush_i) begin
            div_res_o   <= fix_res;
            rd_addr_o   <= rd_q;
            valid_res_o <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
